spi_rd_master: RTL

SPI mode-0 initiator for the FPGA072 register-read protocol. One transaction:
- drives CS low;
- shifts out an 8-bit command byte, MSB first: bit 7 = r_w, bits 6:0 = address;
- waits a fixed gap so the addressed responder can latch its input port;
- clocks in Nbit data bits from MISO, MSB first.

It sits in the host-side FPGA and feeds one `spi_slave_rd`-style responder per address on a shared bus.

---
 rtl/spi_rd_pkg.sv | 21 ++
 rtl/spi_rd_clkgen.sv | 40 ++++
 rtl/spi_rd_master.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/spi_rd_pkg.sv
// Shared constants for the FPGA072 register-read SPI master and its responders.
package spi_rd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_CMD,
    ST_GAP,
    ST_DATA,
    ST_HOLD,
    ST_WAIT
  } state_t;

  localparam int   CMD_BITS = 8;
  localparam logic RW_READ  = 1'b0;

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/spi_rd_clkgen.sv
// SCLK generator: free-running half-period counter while enabled,
// with strobes flagging the clk on which sclk will rise or fall.
module spi_rd_clkgen #(
  parameter int HALF = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic sclk,
  output logic rise,
  output logic fall
);

  localparam int HW = $clog2(HALF) + 1;

  logic [HW-1:0] hcnt_q;
  logic          sclk_q;
  logic          tick;

  assign tick = en && (hcnt_q == '0);
  assign rise = tick & ~sclk_q;
  assign fall = tick & sclk_q;
  assign sclk = sclk_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcnt_q <= '0;
      sclk_q <= 1'b0;
    end else if (!en) begin
      hcnt_q <= HW'(HALF - 1);
      sclk_q <= 1'b0;
    end else if (tick) begin
      hcnt_q <= HW'(HALF - 1);
      sclk_q <= ~sclk_q;
    end else begin
      hcnt_q <= hcnt_q - 1'b1;
    end
  end

endmodule

// File: rtl/spi_rd_master.sv
// SPI mode-0 initiator: command byte out, fixed gap, Nbit data word in.
// All pin outputs are registered from next-state values.
module spi_rd_master
  import spi_rd_pkg::*;
#(
  parameter int Nbit  = 8,
  parameter int HALF  = 4,
  parameter int SETUP = 4,
  parameter int GAP   = 16,
  parameter int HOLD  = 4,
  parameter int IDLE  = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [6:0]      adr,
  input  logic            rw,
  output logic            busy,
  output logic            done,
  output logic [Nbit-1:0] dout,
  output logic            sclk,
  output logic            mosi,
  output logic            cs,
  input  logic            miso
);

  localparam int CMAX = imax(imax(imax(HALF, SETUP), imax(GAP, HOLD)), IDLE);
  localparam int CW   = $clog2(CMAX) + 1;
  localparam int BW   = $clog2(imax(CMD_BITS, Nbit) + 1);

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic [CMD_BITS-1:0]   cmd_q, cmd_d;
  logic [Nbit-1:0]       sh_q, sh_d;
  logic [Nbit-1:0]       dout_q, dout_d;
  logic                  cs_q, mosi_q, busy_q, done_q;
  logic                  sck_en, rise, fall;
  logic [2:0]            bidx;

  assign sck_en = (state_q == ST_CMD) || (state_q == ST_DATA);

  spi_rd_clkgen #(.HALF(HALF)) u_clkgen (
    .clk  (clk),
    .rst  (rst),
    .en   (sck_en),
    .sclk (sclk),
    .rise (rise),
    .fall (fall)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    cmd_d   = cmd_q;
    sh_d    = sh_q;
    dout_d  = dout_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SETUP;
          cmd_d   = {rw, adr};
          cnt_d   = CW'(SETUP - 1);
        end
      end
      ST_SETUP: begin
        if (cnt_q == '0) begin
          state_d = ST_CMD;
          bit_d   = '0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_CMD: begin
        if (fall) begin
          if (bit_q == BW'(CMD_BITS - 1)) begin
            bit_d = '0;
            if (cmd_q[CMD_BITS-1] == RW_READ) begin
              state_d = ST_GAP;
              cnt_d   = CW'(GAP - 1);
            end else begin
              state_d = ST_HOLD;
              cnt_d   = CW'(HOLD - 1);
            end
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      ST_GAP: begin
        if (cnt_q == '0) begin
          state_d = ST_DATA;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_DATA: begin
        if (rise) begin
          sh_d = {sh_q[Nbit-2:0], miso};
        end
        if (fall) begin
          if (bit_q == BW'(Nbit - 1)) begin
            bit_d   = '0;
            state_d = ST_HOLD;
            cnt_d   = CW'(HOLD - 1);
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      ST_HOLD: begin
        if (cnt_q == '0) begin
          state_d = ST_WAIT;
          cnt_d   = CW'(IDLE - 1);
          if (cmd_q[CMD_BITS-1] == RW_READ) begin
            dout_d = sh_q;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // mosi presents the command bit selected by the next bit count
  assign bidx = 3'(CMD_BITS - 1) - bit_d[2:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      cmd_q   <= '0;
      sh_q    <= '0;
      dout_q  <= '0;
      cs_q    <= 1'b1;
      mosi_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      cmd_q   <= cmd_d;
      sh_q    <= sh_d;
      dout_q  <= dout_d;
      cs_q    <= (state_d == ST_IDLE) || (state_d == ST_WAIT);
      mosi_q  <= (state_d == ST_CMD) ? cmd_d[bidx] : 1'b0;
      busy_q  <= (state_d != ST_IDLE);
      done_q  <= (state_q == ST_HOLD) && (state_d == ST_WAIT);
    end
  end

  assign cs   = cs_q;
  assign mosi = mosi_q;
  assign busy = busy_q;
  assign done = done_q;
  assign dout = dout_q;

endmodule
